// File: rtl/thz_pkg.sv
// Shared types and sizing for the THz frame buffer write path.
// Used by the write sequencer and the slot credit counter.
package thz_pkg;

    localparam int NUM_FRAMES    = 30;
    localparam int PIX_PER_FRAME = 8;
    localparam int DATA_W        = 10;
    localparam int ADDR_W        = 4;
    localparam int IDX_W         = $clog2(PIX_PER_FRAME);
    localparam int SLOT_W        = 5;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FRAMES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PIX_PER_FRAME - 1);

    typedef struct packed {
        logic [DATA_W-1:0] pixel;
        logic [ADDR_W-1:0] addr;
    } pixel_entry_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        CAPTURE  = 1'b1
    } wr_state_t;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
    endfunction

endpackage

// File: rtl/thz_slot_credit.sv
// Counts full-but-unreleased frame slots; flags releases seen while empty.
// Shared between the write and read sequencers.
module thz_slot_credit
    import thz_pkg::*;
#(
    parameter int NUM   = NUM_FRAMES,
    parameter int CNT_W = SLOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             err_release_o
);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             err_q;
    logic             dec_ok;

    assign dec_ok = dec_i && (occ_q != '0);

    // Next occupancy: a completion and a release in one cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        case ({inc_i, dec_ok})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Counter and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
            err_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            if (dec_i && (occ_q == '0))
                err_q <= 1'b1;
        end
    end

    assign occupancy_o   = occ_q;
    assign full_o        = (occ_q == CNT_W'(NUM));
    assign err_release_o = err_q;

endmodule

// File: rtl/thz_frame_writer.sv
// Pixel stream to frame buffer write sequencer.
// Assigns pixel index and frame slot, never overwriting an unread frame.
module thz_frame_writer
    import thz_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_data,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              write_en,
    output logic [SLOT_W-1:0] frame_sel,
    output logic [IDX_W-1:0]  pixel_index_in,
    output logic [DATA_W-1:0] pixel_data_in,
    output logic [ADDR_W-1:0] pixel_addr_in,
    output logic              frame_done,
    output logic [SLOT_W-1:0] frame_done_id,
    input  logic              frame_release,
    output logic [SLOT_W-1:0] occupancy,
    output logic              err_short,
    output logic              err_release
);

    wr_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;

    logic              we_q;
    logic [SLOT_W-1:0] sel_q;
    logic [IDX_W-1:0]  pidx_q;
    pixel_entry_t      entry_q;
    logic              done_q;
    logic [SLOT_W-1:0] done_id_q;
    logic              short_q;

    logic              full;
    logic              acc;
    logic              wr;
    logic              last;
    logic [IDX_W-1:0]  widx;

    // Only a new frame is held off when full; a frame in progress always lands.
    assign s_ready = (state_q == CAPTURE) || !full;
    assign acc     = s_valid && s_ready;
    assign wr      = acc && ((state_q == CAPTURE) || s_sof);
    assign widx    = s_sof ? '0 : idx_q;
    assign last    = wr && (widx == LAST_IDX);

    // Frame FSM with pixel index and slot counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        if (last) begin
            state_d = WAIT_SOF;
            idx_d   = '0;
            slot_d  = next_slot(slot_q);
        end else if (wr) begin
            state_d = CAPTURE;
            idx_d   = widx + IDX_W'(1);
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_SOF;
            idx_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

    // Write port register stage; fields hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            sel_q     <= '0;
            pidx_q    <= '0;
            entry_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            short_q   <= 1'b0;
        end else begin
            we_q    <= wr;
            done_q  <= last;
            short_q <= acc && s_sof && (state_q == CAPTURE);
            if (wr) begin
                sel_q         <= slot_q;
                pidx_q        <= widx;
                entry_q.pixel <= s_data;
                entry_q.addr  <= s_addr;
            end
            if (last)
                done_id_q <= slot_q;
        end
    end

    thz_slot_credit u_credit (
        .clk           (clk),
        .rst           (rst),
        .inc_i         (last),
        .dec_i         (frame_release),
        .occupancy_o   (occupancy),
        .full_o        (full),
        .err_release_o (err_release)
    );

    assign write_en       = we_q;
    assign frame_sel      = sel_q;
    assign pixel_index_in = pidx_q;
    assign pixel_data_in  = entry_q.pixel;
    assign pixel_addr_in  = entry_q.addr;
    assign frame_done     = done_q;
    assign frame_done_id  = done_id_q;
    assign err_short      = short_q;

endmodule

// File: tb/tb_thz_frame_writer.sv
// Self-checking bench for thz_frame_writer against a frame-level model.
// Directed scenarios with randomized pixel data and idle gaps.
module tb_thz_frame_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_sof = 1'b0;
    logic [9:0] s_data = '0;
    logic [3:0] s_addr = '0;
    logic       write_en;
    logic [4:0] frame_sel;
    logic [2:0] pixel_index_in;
    logic [9:0] pixel_data_in;
    logic [3:0] pixel_addr_in;
    logic       frame_done;
    logic [4:0] frame_done_id;
    logic       frame_release = 1'b0;
    logic [4:0] occupancy;
    logic       err_short;
    logic       err_release;

    thz_frame_writer dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_sof          (s_sof),
        .s_data         (s_data),
        .s_addr         (s_addr),
        .write_en       (write_en),
        .frame_sel      (frame_sel),
        .pixel_index_in (pixel_index_in),
        .pixel_data_in  (pixel_data_in),
        .pixel_addr_in  (pixel_addr_in),
        .frame_done     (frame_done),
        .frame_done_id  (frame_done_id),
        .frame_release  (frame_release),
        .occupancy      (occupancy),
        .err_short      (err_short),
        .err_release    (err_release)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // reference model: frame-level bookkeeping in plain integers
    bit in_frame;
    int pix_cnt;
    int slot;
    int occ;
    bit m_err_rel;
    bit e_we, e_done, e_short;
    int e_sel, e_idx, e_data, e_addr, e_done_id;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_frame = 0; pix_cnt = 0; slot = 0; occ = 0; m_err_rel = 0;
        e_we = 0; e_done = 0; e_short = 0;
        e_sel = 0; e_idx = 0; e_data = 0; e_addr = 0; e_done_id = 0;
    endtask

    task automatic check_outputs();
        check("write_en", int'(write_en), int'(e_we));
        check("frame_sel", int'(frame_sel), e_sel);
        check("pixel_index", int'(pixel_index_in), e_idx);
        check("pixel_data", int'(pixel_data_in), e_data);
        check("pixel_addr", int'(pixel_addr_in), e_addr);
        check("frame_done", int'(frame_done), int'(e_done));
        check("frame_done_id", int'(frame_done_id), e_done_id);
        check("occupancy", int'(occupancy), occ);
        check("err_short", int'(err_short), int'(e_short));
        check("err_release", int'(err_release), int'(m_err_rel));
    endtask

    task automatic step(input bit v, input bit sof, input int d, input int a,
                        input bit rel, input bit r);
        bit rdy;
        bit comp;
        @(negedge clk);
        s_valid = v; s_sof = sof; s_data = 10'(d); s_addr = 4'(a);
        frame_release = rel; rst = r;
        rdy = in_frame || (occ < 30);
        #1 check("s_ready", int'(s_ready), int'(rdy));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            comp = 0;
            e_we = 0; e_done = 0; e_short = 0;
            if (v && rdy && (in_frame || sof)) begin
                if (sof) begin
                    e_short = in_frame;
                    pix_cnt = 0;
                end
                e_we = 1; e_sel = slot; e_idx = pix_cnt; e_data = d; e_addr = a;
                pix_cnt++;
                in_frame = 1;
                if (pix_cnt == 8) begin
                    e_done = 1; e_done_id = slot; comp = 1;
                    slot = (slot + 1) % 30; pix_cnt = 0; in_frame = 0;
                end
            end
            if (rel && occ == 0) m_err_rel = 1;
            else occ = occ - int'(rel);
            occ = occ + int'(comp);
        end
        #1 check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_frame(input bit rel_last);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            step(1, i == 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 15)),
                 rel_last && i == 7, 0);
        end
    endtask

    initial begin
        model_reset();
        // reset state
        step(0, 0, 0, 0, 0, 1);
        check("reset_we", int'(write_en), 0);
        check("reset_occ", int'(occupancy), 0);
        check("reset_ready", int'(s_ready), 1);

        // back-to-back frame, data 100..107, addr 0..7
        for (int i = 0; i < 8; i++) step(1, i == 0, 100 + i, i, 0, 0);
        check("f1_done_id", int'(frame_done_id), 0);
        check("f1_last_data", int'(pixel_data_in), 107);
        idle(1);
        check("f1_occ", int'(occupancy), 1);

        // non-sof beats dropped, frame goes to next slot
        for (int i = 0; i < 3; i++) step(1, 0, 500 + i, i, 0, 0);
        send_frame(0);
        check("f2_slot", int'(frame_done_id), 1);

        // short frame then restart in same slot
        for (int i = 0; i < 4; i++) step(1, i == 0, 200 + i, i, 0, 0);
        send_frame(0);
        check("f3_slot", int'(frame_done_id), 2);
        idle(1);
        check("f3_occ", int'(occupancy), 3);

        // fill all slots, back-pressure, release, wrap
        do_reset();
        for (int f = 0; f < 30; f++) send_frame(0);
        idle(1);
        check("full_occ", int'(occupancy), 30);
        check("full_ready", int'(s_ready), 0);
        step(1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("rel_occ", int'(occupancy), 29);
        send_frame(0);
        check("wrap_sel", int'(frame_sel), 0);

        // release coincident with completion; release underflow
        do_reset();
        send_frame(0);
        send_frame(1);
        check("coinc_occ", int'(occupancy), 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("err_rel_set", int'(err_release), 1);
        idle(3);
        check("err_rel_sticky", int'(err_release), 1);
        do_reset();
        check("err_rel_clr", int'(err_release), 0);

        // reset mid-frame
        send_frame(0);
        for (int i = 0; i < 5; i++) step(1, i == 0, 300 + i, i, 0, 0);
        step(1, 0, 305, 5, 0, 1);
        check("rst_we", int'(write_en), 0);
        check("rst_occ", int'(occupancy), 0);
        step(1, 1, 400, 9, 0, 0);
        check("rst_new_sel", int'(frame_sel), 0);
        check("rst_new_idx", int'(pixel_index_in), 0);
        for (int i = 1; i < 8; i++) step(1, 0, 400 + i, 9, 0, 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
